// File: rtl/acc_cpu_pkg.sv
// ============================================================================
// acc_cpu_pkg : shared types, opcodes and field positions for the accumulator CPU
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package acc_cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_DBL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMM = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  // Instruction field positions: I at the top, 3-bit opcode just below it
  function automatic int ind_bit(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int op_msb(input int data_w);
    return data_w - 2;
  endfunction

  function automatic int op_lsb(input int data_w);
    return data_w - 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_cpu_mem.sv
// ============================================================================
// acc_cpu_mem : register-array memory, one write port, core and debug async reads
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module acc_cpu_mem
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int C_DEPTH = 1 << ADDR_W;

  // Contents are deliberately not reset
  logic [DATA_W-1:0] mem_q [C_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/acc_cpu_param.sv
// ============================================================================
// acc_cpu_param : parametrised 5-state accumulator CPU with program-load port
// Revision      : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_init_i,
  input  logic [DATA_W-1:0] ac_init_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic [DATA_W-1:0] ac_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              e_flag_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              instr_done_o
);

  localparam int C_IND    = ind_bit(DATA_W);
  localparam int C_OP_MSB = op_msb(DATA_W);
  localparam int C_OP_LSB = op_lsb(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              e_q, e_d;
  logic [2:0]        op_q, op_d;
  logic              ind_q, ind_d;
  logic              done_q;

  logic              w_idle_or_halt;
  logic [DATA_W-1:0] w_mem_rd;
  logic              w_t4_we;
  logic [DATA_W-1:0] w_t4_wdata;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_idle_or_halt = (state_q == ST_IDLE) || (state_q == ST_HALT);

  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    pc_d       = pc_q;
    ar_d       = ar_q;
    ir_d       = ir_q;
    e_d        = e_q;
    op_d       = op_q;
    ind_d      = ind_q;
    w_t4_we    = 1'b0;
    w_t4_wdata = ac_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          pc_d    = pc_init_i;
          ac_d    = ac_init_i;
          e_d     = 1'b0;
          state_d = ST_T0;
        end
      end
      ST_T0: begin
        ar_d    = pc_q;
        state_d = ST_T1;
      end
      ST_T1: begin
        ir_d    = w_mem_rd;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_T2;
      end
      ST_T2: begin
        ar_d    = ir_q[ADDR_W-1:0];
        op_d    = ir_q[C_OP_MSB:C_OP_LSB];
        ind_d   = ir_q[C_IND];
        state_d = ST_T3;
      end
      ST_T3: begin
        // JMP never indirects, so AR keeps the raw address field for it
        if (ind_q && (op_q != OP_SYS)) begin
          ar_d = w_mem_rd[ADDR_W-1:0];
        end
        state_d = ST_T4;
      end
      ST_T4: begin
        state_d = ST_T0;
        case (op_q)
          OP_ADD: {e_d, ac_d} = {1'b0, ac_q} + {1'b0, w_mem_rd};
          OP_SUB: {e_d, ac_d} = {1'b0, ac_q} - {1'b0, w_mem_rd};
          OP_XOR: ac_d = ac_q ^ w_mem_rd;
          OP_DBL: begin
            w_t4_we    = 1'b1;
            w_t4_wdata = w_mem_rd + w_mem_rd;
            e_d        = w_mem_rd[DATA_W-1];
          end
          OP_LDA: ac_d = w_mem_rd;
          OP_STA: begin
            w_t4_we    = 1'b1;
            w_t4_wdata = ac_q;
          end
          OP_CMM: begin
            w_t4_we    = 1'b1;
            w_t4_wdata = ~w_mem_rd;
          end
          default: begin
            if (ind_q) begin
              pc_d = ir_q[ADDR_W-1:0];
            end else begin
              state_d = ST_HALT;
            end
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load port and T4 writes are exclusive by state; reset kills either write
  assign w_mem_we    = !rst && (w_t4_we || (w_idle_or_halt && ld_en_i));
  assign w_mem_waddr = (state_q == ST_T4) ? ar_q : ld_addr_i;
  assign w_mem_wdata = (state_q == ST_T4) ? w_t4_wdata : ld_data_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ac_q    <= '0;
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      e_q     <= 1'b0;
      op_q    <= '0;
      ind_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      e_q     <= e_d;
      op_q    <= op_d;
      ind_q   <= ind_d;
      done_q  <= (state_q == ST_T4);
    end
  end

  acc_cpu_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk       (clk),
    .we_i      (w_mem_we),
    .waddr_i   (w_mem_waddr),
    .wdata_i   (w_mem_wdata),
    .raddr_i   (ar_q),
    .rdata_o   (w_mem_rd),
    .dbg_addr_i(dbg_addr_i),
    .dbg_data_o(dbg_data_o)
  );

  assign ac_o         = ac_q;
  assign pc_o         = pc_q;
  assign e_flag_o     = e_q;
  assign busy_o       = !w_idle_or_halt;
  assign halted_o     = (state_q == ST_HALT);
  assign instr_done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_cpu_param.sv
// ============================================================================
// tb_acc_cpu_param : directed self-checking bench for acc_cpu_param (8-bit / 16-word)
// Revision         : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_acc_cpu_param;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] pc_init_i;
  logic [DW-1:0] ac_init_i;
  logic          ld_en_i;
  logic [AW-1:0] ld_addr_i;
  logic [DW-1:0] ld_data_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_data_o;
  logic [DW-1:0] ac_o;
  logic [AW-1:0] pc_o;
  logic          e_flag_o;
  logic          busy_o;
  logic          halted_o;
  logic          instr_done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dones    = 0;

  always #5 clk = ~clk;

  acc_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .pc_init_i   (pc_init_i),
    .ac_init_i   (ac_init_i),
    .ld_en_i     (ld_en_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_data_o  (dbg_data_o),
    .ac_o        (ac_o),
    .pc_o        (pc_o),
    .e_flag_o    (e_flag_o),
    .busy_o      (busy_o),
    .halted_o    (halted_o),
    .instr_done_o(instr_done_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (instr_done_o) dones++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en_i   = 1'b1;
    ld_addr_i = a;
    ld_data_i = d;
    tick();
    ld_en_i   = 1'b0;
  endtask

  task automatic mem_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    dbg_addr_i = a;
    #1;
    check(tag, dbg_data_o, exp);
  endtask

  task automatic go(input logic [AW-1:0] pc, input logic [DW-1:0] ac);
    pc_init_i = pc;
    ac_init_i = ac;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    cyc       = 0;
    dones     = 0;
  endtask

  task automatic wait_halt(input string tag);
    while (!halted_o && cyc < 300) tick();
    check(tag, halted_o, 1);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; pc_init_i = '0; ac_init_i = '0;
    ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; dbg_addr_i = '0;
    tick(); tick();
    check("rst_ac", ac_o, 8'h00);
    check("rst_pc", pc_o, 4'h0);
    check("rst_e", e_flag_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_done", instr_done_o, 0);
    rst = 1'b0;
    tick();

    // LDA A, ADD B (carry), STA C, HLT
    load(4'h0, 8'h4A); load(4'h1, 8'h0B); load(4'h2, 8'h5C); load(4'h3, 8'h70);
    load(4'hA, 8'h05); load(4'hB, 8'hFE);
    go(4'h0, 8'h00);
    check("p1_busy", busy_o, 1);
    wait_halt("p1_halt");
    check("p1_cycles", cyc, 20);
    check("p1_dones", dones, 4);
    check("p1_ac", ac_o, 8'h03);
    check("p1_e", e_flag_o, 1);
    check("p1_pc", pc_o, 4'h4);
    mem_chk("p1_mc", 4'hC, 8'h03);

    // Indirect LDA, with a load-port pulse while busy
    load(4'h0, 8'hCA); load(4'hA, 8'h0D); load(4'hD, 8'h77); load(4'h1, 8'h70);
    load(4'h7, 8'h33);
    go(4'h0, 8'h00);
    tick();
    ld_en_i = 1'b1; ld_addr_i = 4'h7; ld_data_i = 8'h99;
    tick();
    ld_en_i = 1'b0;
    wait_halt("ind_halt");
    check("ind_cycles", cyc, 10);
    check("ind_ac", ac_o, 8'h77);
    check("ind_pc", pc_o, 4'h2);
    check("ind_e", e_flag_o, 0);
    mem_chk("ld_busy_m7", 4'h7, 8'h33);

    // SUB with borrow
    load(4'h0, 8'h1A); load(4'hA, 8'h05); load(4'h1, 8'h70);
    go(4'h0, 8'h03);
    wait_halt("sub_halt");
    check("sub_ac", ac_o, 8'hFE);
    check("sub_e", e_flag_o, 1);

    // XOR leaves E alone
    load(4'h0, 8'h2A); load(4'hA, 8'h0F); load(4'h1, 8'h70);
    go(4'h0, 8'h3C);
    wait_halt("xor_halt");
    check("xor_ac", ac_o, 8'h33);
    check("xor_e", e_flag_o, 0);

    // CMM
    load(4'h0, 8'h6A); load(4'hA, 8'h0F); load(4'h1, 8'h70);
    go(4'h0, 8'h00);
    wait_halt("cmm_halt");
    mem_chk("cmm_ma", 4'hA, 8'hF0);
    check("cmm_e", e_flag_o, 0);

    // JMP
    load(4'h0, 8'hF5); load(4'h5, 8'h70);
    go(4'h0, 8'h00);
    wait_halt("jmp_halt");
    check("jmp_cycles", cyc, 10);
    check("jmp_pc", pc_o, 4'h6);

    // DBL with carry out and PC wrap
    load(4'hF, 8'h3E); load(4'hE, 8'h81); load(4'h0, 8'h70);
    go(4'hF, 8'h00);
    wait_halt("wrap_halt");
    mem_chk("dbl_me", 4'hE, 8'h02);
    check("dbl_e", e_flag_o, 1);
    check("wrap_pc", pc_o, 4'h1);

    // start while busy is ignored
    load(4'h0, 8'h4A); load(4'hA, 8'h05); load(4'h1, 8'h70);
    go(4'h0, 8'h00);
    tick(); tick();
    start_i = 1'b1; pc_init_i = 4'h8; ac_init_i = 8'hFF;
    tick();
    start_i = 1'b0;
    wait_halt("sb_halt");
    check("sb_cycles", cyc, 10);
    check("sb_ac", ac_o, 8'h05);
    check("sb_pc", pc_o, 4'h2);

    // Reset during T4 of STA suppresses the write
    load(4'hC, 8'h11); load(4'h0, 8'h5C); load(4'h1, 8'h70);
    go(4'h0, 8'hAA);
    tick(); tick(); tick(); tick();
    check("t4_busy", busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_chk("rst_mc", 4'hC, 8'h11);
    mem_chk("rst_m0", 4'h0, 8'h5C);
    check("rst2_ac", ac_o, 8'h00);
    check("rst2_pc", pc_o, 4'h0);
    check("rst2_busy", busy_o, 0);
    check("rst2_halted", halted_o, 0);

    // Same program from IDLE completes the store
    go(4'h0, 8'hAA);
    wait_halt("sta_halt");
    mem_chk("sta_mc", 4'hC, 8'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_cpu_param.md
# acc_cpu_param

Parametrised accumulator CPU with start/halt control, a carry/borrow flag, jump, and a program-load port. It executes fixed five-state instructions (fetch, read, decode, indirect, execute) against an internal 2^ADDR_W × DATA_W memory. The testbench, or a future SoC wrapper, loads the program through the load port and then issues `start`. It supersedes the fixed 8-bit/16-word CPU as the codebase's processing core.

## Interface
- `DATA_W`, 8: word width of AC, IR and memory; must be ≥ ADDR_W+4
- `ADDR_W`, 4: address width of PC and AR; memory depth is 2^ADDR_W
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: reset, synchronous and active-high
- `start` in 1: begin execution; sampled in IDLE or HALT only
- `pc_init` in ADDR_W: PC loaded on an accepted start
- `ac_init` in DATA_W: AC loaded on an accepted start
- `ld_en` in 1: program-load write strobe; honoured in IDLE or HALT only
- `ld_addr` in ADDR_W, `ld_data` in DATA_W: load address and data
- `dbg_addr` in ADDR_W / `dbg_data` out DATA_W: combinational memory read-back
- `ac` out DATA_W, `pc` out ADDR_W, `e_flag` out 1: architectural state
- `busy` out 1: state is neither IDLE nor HALT
- `halted` out 1: state is HALT
- `instr_done` out 1: one-cycle pulse after each EXEC

## Operation
- Instruction word: bit DATA_W-1 = I (indirect); bits DATA_W-2..DATA_W-4 = opcode; bits ADDR_W-1..0 = address. Any remaining bits are ignored.
- States: IDLE, T0, T1, T2, T3, T4, HALT.
  - T0: AR←PC.
  - T1: IR←M[AR]; PC←PC+1 (mod 2^ADDR_W).
  - T2: AR←IR address field; latch opcode and I.
  - T3: if I=1 and opcode≠111, AR←M[AR][ADDR_W-1:0]; otherwise no-op.
  - T4: execute, then go to T0, or to HALT on HLT.
- Opcodes (result is the value read before the update):
  - 000 ADD: {E,AC}←AC+M[AR]
  - 001 SUB: {E,AC}←{0,AC}−{0,M[AR]}; E=1 means borrow
  - 010 XOR: AC←AC^M[AR]
  - 011 DBL: M[AR]←M[AR]+M[AR]; E←old M[AR] MSB
  - 100 LDA: AC←M[AR]
  - 101 STA: M[AR]←AC
  - 110 CMM: M[AR]←~M[AR]
  - 111 with I=0 is HLT; 111 with I=1 is JMP: PC←IR address field, no indirection
- E is changed only by ADD, SUB and DBL.
- Arithmetic is modulo 2^DATA_W; carry and borrow go to E only.
- start accepted in IDLE/HALT: PC←pc_init, AC←ac_init, E←0, next state T0. start is ignored while busy.
- ld_en in IDLE/HALT writes M[ld_addr]←ld_data. ld_en is ignored while busy. ld_en together with start in the same cycle performs both.

## Timing
- Reset values: state IDLE; AC, PC, AR, IR and E are 0; busy=0, halted=0, instr_done=0. Memory contents are not reset.
- Reset in any state, including mid-T4, takes priority: the pending memory write is suppressed and all registers take their reset values.
- Every instruction takes exactly 5 cycles (T0–T4). The first T0 is the cycle after the start edge.
- instr_done is high during the cycle after each T4 edge, including HLT.
- N instructions ending in HLT: halted rises exactly 5N cycles after the start edge.
- Memory writes from T4 and from the load port become visible on dbg_data the cycle after the write edge.
- PC wraps from 2^ADDR_W−1 to 0 without error.

## Structure
- Package `acc_cpu_pkg` holds:
  - state enum
  - opcode localparams (OP_ADD..OP_SYS)
  - field-position functions derived from DATA_W and ADDR_W
- Sub-module `acc_cpu_mem`: register-array memory with one write port and two asynchronous read ports (core and debug). The core muxes the load port and T4 writes onto the single write port, which is safe because the two are exclusive by state.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4.
- Program/ALU/carry: load M0=4A, M1=0B, M2=5C, M3=70, MA=05, MB=FE; start with pc_init=0 → AC=03, E=1, MC=03; halted exactly 20 cycles after start; 4 instr_done pulses.
- Indirect: M0=CA, MA=0D, MD=77, M1=70 → AC=77, PC=2 at halt.
- SUB borrow, XOR, CMM:
  - ac_init=03, M0=1A, MA=05, M1=70 → AC=FE, E=1
  - separate run: M0=6A, MA=0F → MA=F0
- JMP and wrap:
  - M0=F5, M5=70 → PC=6 at halt
  - separate run: pc_init=F, MF=3E, ME=81, M0=70 → ME=02, E=1, PC=1 at halt
- Reset and load gating:
  - ld_en pulsed while busy → memory unchanged
  - rst asserted during T4 of STA → target word unchanged, AC=0, PC=0, IDLE, other memory preserved
  - start during busy ignored
